// File: rtl/bram_slice_reader.sv
// Reads LENGTH bit-sliced rows of one PE block BRAM and streams the 16 lanes back
// out as word-parallel values over a valid/ready port.
module bram_slice_reader #(
  parameter int unsigned SIZE            = 2,
  parameter int unsigned MAX_WORD_LENGTH = 32,
  parameter int unsigned ADDR_W          = 10,
  parameter int unsigned LANES           = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 blk_i,
  input  logic [7:0]                 blk_j,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [5:0]                 length,
  output logic [7:0]                 bram_i,
  output logic [7:0]                 bram_j,
  output logic                       bram_en,
  output logic [ADDR_W-1:0]          bram_addr,
  input  logic [LANES-1:0]           bram_dout,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [3:0]                 word_lane,
  output logic [MAX_WORD_LENGTH-1:0] word_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned ROW_W = $clog2(MAX_WORD_LENGTH);
  localparam logic [3:0]  LAST_LANE = 4'(LANES - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUT, DONE} state_t;

  state_t                     state, state_d;
  logic [5:0]                 r, r_d, len_q, len_d;
  logic [ADDR_W-1:0]          base_q, base_d, bram_addr_d;
  logic [3:0]                 lane, lane_d, word_lane_d;
  logic [7:0]                 bram_i_d, bram_j_d;
  logic                       bram_en_d, word_valid_d, busy_d, done_d, err_d;
  logic [MAX_WORD_LENGTH-1:0] word_data_d;
  logic                       clr_buf, start_bad;
  logic                       cap_en;
  logic [ROW_W-1:0]           cap_row;
  logic [MAX_WORD_LENGTH-1:0] tbuf    [LANES];
  logic [MAX_WORD_LENGTH-1:0] buf_nxt [LANES];

  assign start_bad = (length == 6'd0) || (length > 6'(MAX_WORD_LENGTH)) ||
                     (blk_i >= 8'(SIZE)) || (blk_j >= 8'(SIZE));

  // Transpose: read data returning this cycle lands in column cap_row of every lane.
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      buf_nxt[k] = tbuf[k];
      if (cap_en) buf_nxt[k][cap_row] = bram_dout[k];
    end
  end

  always_comb begin
    state_d      = state;
    r_d          = r;
    len_d        = len_q;
    base_d       = base_q;
    lane_d       = lane;
    clr_buf      = 1'b0;
    bram_en_d    = 1'b0;
    bram_addr_d  = bram_addr;
    bram_i_d     = bram_i;
    bram_j_d     = bram_j;
    word_valid_d = 1'b0;
    word_lane_d  = word_lane;
    word_data_d  = word_data;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (start_bad) begin
            err_d = 1'b1;
          end else begin
            state_d     = READ;
            len_d       = length;
            base_d      = base_addr;
            bram_i_d    = blk_i;
            bram_j_d    = blk_j;
            clr_buf     = 1'b1;
            bram_en_d   = 1'b1;
            bram_addr_d = base_addr;
            r_d         = 6'd1;
            busy_d      = 1'b1;
          end
        end
      end
      READ: begin
        if (r == len_q) begin
          state_d = DRAIN;
        end else begin
          bram_en_d   = 1'b1;
          bram_addr_d = base_q + ADDR_W'(r);
          r_d         = r + 6'd1;
        end
      end
      DRAIN: begin
        state_d      = OUT;
        lane_d       = 4'd0;
        word_valid_d = 1'b1;
        word_lane_d  = 4'd0;
        word_data_d  = buf_nxt[0];
      end
      OUT: begin
        word_valid_d = 1'b1;
        if (word_ready) begin
          if (lane == LAST_LANE) begin
            state_d      = DONE;
            word_valid_d = 1'b0;
            word_lane_d  = 4'd0;
            word_data_d  = '0;
            done_d       = 1'b1;
          end else begin
            lane_d      = lane + 4'd1;
            word_lane_d = lane + 4'd1;
            word_data_d = buf_nxt[lane + 4'd1];
          end
        end
      end
      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        bram_i_d    = 8'd0;
        bram_j_d    = 8'd0;
        bram_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      r          <= 6'd0;
      len_q      <= 6'd0;
      base_q     <= '0;
      lane       <= 4'd0;
      cap_en     <= 1'b0;
      cap_row    <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      bram_i     <= 8'd0;
      bram_j     <= 8'd0;
      word_valid <= 1'b0;
      word_lane  <= 4'd0;
      word_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int k = 0; k < int'(LANES); k++) tbuf[k] <= '0;
    end else begin
      state      <= state_d;
      r          <= r_d;
      len_q      <= len_d;
      base_q     <= base_d;
      lane       <= lane_d;
      cap_en     <= bram_en;
      cap_row    <= ROW_W'(r - 6'd1);
      bram_en    <= bram_en_d;
      bram_addr  <= bram_addr_d;
      bram_i     <= bram_i_d;
      bram_j     <= bram_j_d;
      word_valid <= word_valid_d;
      word_lane  <= word_lane_d;
      word_data  <= word_data_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      for (int k = 0; k < int'(LANES); k++)
        tbuf[k] <= clr_buf ? '0 : buf_nxt[k];
    end
  end

endmodule

// File: tb/tb_bram_slice_reader.sv
// Randomized bench for bram_slice_reader against a row-array BRAM model and a
// per-lane bit-gathering reference.
module tb_bram_slice_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  blk_i, blk_j;
  logic [9:0]  base_addr;
  logic [5:0]  length;
  logic [7:0]  bram_i, bram_j;
  logic        bram_en;
  logic [9:0]  bram_addr;
  logic [15:0] bram_dout = '0;
  logic        word_valid, word_ready;
  logic [3:0]  word_lane;
  logic [31:0] word_data;
  logic        busy, done, err;

  logic [15:0] mem [0:1][0:1][0:1023];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bram_slice_reader dut (
    .clk(clk), .reset(reset), .start(start), .blk_i(blk_i), .blk_j(blk_j),
    .base_addr(base_addr), .length(length), .bram_i(bram_i), .bram_j(bram_j),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .word_valid(word_valid), .word_ready(word_ready), .word_lane(word_lane),
    .word_data(word_data), .busy(busy), .done(done), .err(err)
  );

  // One-cycle-latency BRAM read port
  always @(posedge clk)
    if (bram_en && bram_i < 8'd2 && bram_j < 8'd2)
      bram_dout <= mem[bram_i[0]][bram_j[0]][bram_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane word = bit `lane` of each of the len rows starting at base (wrapping).
  function automatic logic [31:0] exp_word(input int bi, input int bj, input int base,
                                           input int len, input int lane);
    logic [31:0] w = '0;
    logic [15:0] row;
    for (int b = 0; b < len; b++) begin
      row  = mem[bi][bj][(base + b) % 1024];
      w[b] = row[lane];
    end
    return w;
  endfunction

  task automatic xfer(input int bi, input int bj, input int base, input int len,
                      input int rmode, input bit poke);
    int nrow = 0, nword = 0, err_seen = 0;
    bit got_done = 0, seen_valid = 0, stalled = 0, poked = 0;
    logic [3:0]  held_lane = '0;
    logic [31:0] held_data = '0;
    @(negedge clk);
    blk_i = 8'(bi); blk_j = 8'(bj); base_addr = 10'(base); length = 6'(len);
    start = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 400 && !got_done; k++) begin
      start = 1'b0;
      if (k == 1) check("blk_sel", {bram_i, bram_j}, {8'(bi), 8'(bj)});
      check("busy", busy, 1);
      if (err) err_seen++;
      if (bram_en) begin
        check("addr", bram_addr, (base + nrow) % 1024);
        nrow++;
      end
      if (done) begin
        check("done_words", nword, 16);
        check("rows", nrow, len);
        if (rmode == 0) check("done_cycle", k, len + 18);
        got_done = 1;
      end
      if (word_valid) begin
        if (!seen_valid) begin
          check("first_valid", k, len + 2);
          seen_valid = 1;
        end
        if (stalled) begin
          check("stall_lane", word_lane, held_lane);
          check("stall_data", word_data, held_data);
        end
        check("lane", word_lane, nword);
        check("data", word_data, exp_word(bi, bj, base, len, nword));
        check("blk_hold", {bram_i, bram_j}, {8'(bi), 8'(bj)});
      end
      if (poke && word_valid && nword == 5 && !poked) begin
        start = 1'b1; blk_i = 8'd1; blk_j = 8'd0; base_addr = 10'd7; length = 6'd3;
        poked = 1;
      end
      case (rmode)
        0:       word_ready = 1'b1;
        1:       word_ready = (k % 4 == 0) || (k % 4 == 3);
        default: word_ready = 1'($urandom);
      endcase
      stalled   = word_valid && !word_ready;
      held_lane = word_lane;
      held_data = word_data;
      if (word_valid && word_ready) nword++;
      if (!got_done) @(negedge clk);
    end
    start = 1'b0;
    check("timeout", got_done, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("err_busy", err_seen, 0);
  endtask

  task automatic illegal(input int bi, input int bj, input int len, input string tag);
    @(negedge clk);
    blk_i = 8'(bi); blk_j = 8'(bj); base_addr = 10'd0; length = 6'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, bram_en, 0);
    @(negedge clk);
    check({tag, "_err_clr"}, err, 0);
    check({tag, "_en2"}, {bram_en, busy}, 0);
  endtask

  task automatic reset_mid();
    int dones = 0;
    @(negedge clk);
    blk_i = 8'd0; blk_j = 8'd1; base_addr = 10'd100; length = 6'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_read", bram_en, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ctl", {bram_en, word_valid, busy, done, err, bram_addr, bram_i, bram_j, word_lane}, 0);
    check("rst_data", word_data, 0);
    reset = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
    check("rst_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; blk_i = '0; blk_j = '0; base_addr = '0; length = '0;
    word_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int a = 0; a < 1024; a++) mem[i][j][a] = 16'($urandom);
    // Block (0,0): lane k holds the value k
    for (int rr = 0; rr < 32; rr++)
      for (int k = 0; k < 16; k++) mem[0][0][rr][k] = ((k >> rr) & 1) != 0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {bram_en, word_valid, busy, done, err, bram_addr, bram_i, bram_j, word_lane}, 0);
    check("reset_data", word_data, 0);
    reset = 1'b1;

    xfer(0, 0, 0, 32, 0, 0);
    xfer(0, 0, 0, 32, 1, 0);
    xfer(1, 1, 1020, 8, 0, 0);
    illegal(0, 0, 0, "len0");
    illegal(0, 0, 33, "len33");
    illegal(2, 0, 4, "blk2");
    reset_mid();
    xfer(0, 1, 100, 32, 0, 0);
    xfer(1, 0, 500, 12, 0, 1);
    for (int t = 0; t < 6; t++)
      xfer(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1023)), int'($urandom_range(1, 32)), 2, t[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
